id_ex_issue: RTL
================

# id_ex_issue

Decode-and-issue stage of the RISCV-Lite pipeline. It takes the fetched instruction and its PC from IF and reads the register file. It builds the ALU control code and both ALU operands, then holds them in the ID/EX pipeline register for the ALU in EX. The block also detects load-use hazards, inserts bubbles, and honours branch flushes and EX backpressure.

## Interface
Parameters:
- XLEN, 32, datapath width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  IF has an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  32  instruction word
- in_pc  in  32  instruction PC
- rf_raddr1, rf_raddr2  out  5 each  combinational RF read addresses (instr[19:15], instr[24:20])
- rf_rdata1, rf_rdata2  in  32 each  combinational RF read data
- flush  in  1  taken branch/jump in EX; kill the slot
- out_valid  out  1  ID/EX register holds an instruction
- out_ready  in  1  EX consumes the register this cycle
- out_alu_ctrl  out  ALUControl_Enum  ALU operation
- out_op1, out_op2  out  32 each  ALU operands
- out_rs2_data  out  32  store data
- out_imm, out_pc  out  32 each  branch/jump target inputs
- out_rd  out  5  destination register
- out_reg_write, out_mem_read, out_mem_write, out_is_branch, out_is_jump, out_illegal  out  1 each  control flags

## Operation
Decode table (anything not listed is illegal):
- OP 0110011, f3 000: f7 0000000 gives ADD; f7 0100000 gives SUB. f3 100 gives XOR; f3 111 gives AND. op1=rs1, op2=rs2, reg_write=1.
- OP-IMM 0010011: f3 000 ADD, 100 XOR, 111 AND with op2=I-imm. f3 001 with f7 0 gives SLL; f3 101 with f7 0100000 gives SRA; for both, op2=zero-extended shamt. reg_write=1.
- LOAD 0000011 f3 010: ADD, op1=rs1, op2=I-imm, mem_read=1, reg_write=1.
- STORE 0100011 f3 010: ADD, op1=rs1, op2=S-imm, rs2_data=rs2, mem_write=1.
- BRANCH 1100011: f3 001 gives BNE; f3 101 gives BLE. op1=rs1, op2=rs2, imm=B-imm, is_branch=1.
- LUI 0110111: ADD, op1=0, op2=U-imm. AUIPC 0010111: ADD, op1=pc, op2=U-imm. reg_write=1 for both.
- JAL 1101111: ADD, op1=pc, op2=4, imm=J-imm, is_jump=1, reg_write=1.

Field rules:
- rd=0 always forces reg_write=0.
- An illegal instruction issues as ADD with all control flags 0 except out_illegal=1.
- Immediates are sign-extended to 32 bits.

Load-use hazard:
- stall = out_valid & out_mem_read & out_rd≠0 & ((rs1 used & rs1==out_rd) | (rs2 used & rs2==out_rd)).
- rs1 is used by OP, OP-IMM, LOAD, STORE and BRANCH. rs2 is used by OP, STORE and BRANCH.

Handshake:
- in_ready = ~flush & ~stall & (~out_valid | out_ready).
- Register load happens on in_valid & in_ready.
- If stall & out_ready, a bubble loads (out_valid←0).
- If ~out_ready & out_valid, every out_* field holds stable.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on out_* after edge N.
- Throughput is 1 instruction per cycle with no hazard and out_ready=1.
- A load-use hazard costs exactly 1 bubble cycle.
- flush is sampled at the edge and has priority over everything except rst. Next cycle out_valid=0, and the input is not accepted in the flush cycle.
- rst has priority over everything; reset mid-stream discards the held instruction. Reset values:
  - out_valid=0, in_ready follows its equation (1 after reset)
  - out_alu_ctrl=ADD
  - all data outputs 0, all flags 0
- rf_raddr* are combinational from in_instr and are valid whenever in_valid=1.
- With flush and out_ready=0 in the same cycle, flush still clears out_valid.

## Structure
- my_pkg holds:
  - ALUControl_Enum (existing)
  - opcode constants OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL
  - funct3/funct7 constants
  - packed struct id_ex_t carrying all out_* fields, so that the register is a single struct
- Sub-module id_imm_gen is combinational: instr maps to I/S/B/U/J immediates.
- The top-level holds the decoder, the hazard unit and the ID/EX register.

## Test plan
- add x3,x1,x2 (0x002081B3), rdata1=5, rdata2=7: next cycle ADD, op1=5, op2=7, rd=3, reg_write=1.
- sub x2,x1,x2 (0x40208133), rdata1=10, rdata2=3: SUB, op1=10, op2=3. srai x4,x1,31: SRA, op2=31. bne x1,x2,-8: BNE, is_branch=1, imm=0xFFFFFFF8.
- lw x5,0(x1) then add x6,x5,x0 back-to-back with out_ready=1: in_ready=0 for one cycle, one bubble, then add issues with rs1=5.
- out_ready=0 for 3 cycles with out_valid=1: all out_* stable and in_ready=0. out_ready=1: the next instruction issues the following cycle.
- flush with in_valid=1 and a valid held instruction: out_valid=0 next cycle and the input is not consumed. rst mid-stream: outputs return to their reset values.
- instr 0x00000000: out_illegal=1, reg_write=0, mem_read=0, mem_write=0. addi x0,x0,5: reg_write=0.

Source files
------------

// File: rtl/my_pkg.sv
// Shared types and encodings for the RISCV-Lite decode/issue slice.
// ALU codes, opcode/funct constants and the ID/EX bundle.
package my_pkg;

  localparam int DW = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_XOR = 4'd2,
    ALU_AND = 4'd3,
    ALU_SLL = 4'd4,
    ALU_SRA = 4'd5,
    ALU_BNE = 4'd6,
    ALU_BLE = 4'd7
  } ALUControl_Enum;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRA = 3'b101;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLE = 3'b101;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic           valid;
    ALUControl_Enum alu_ctrl;
    logic [DW-1:0]  op1;
    logic [DW-1:0]  op2;
    logic [DW-1:0]  rs2_data;
    logic [DW-1:0]  imm;
    logic [DW-1:0]  pc;
    logic [4:0]     rd;
    logic           reg_write;
    logic           mem_read;
    logic           mem_write;
    logic           is_branch;
    logic           is_jump;
    logic           illegal;
  } id_ex_t;

endpackage

// File: rtl/id_imm_gen.sv
// Immediate generator: sign-extended I/S/B/U/J immediates.
// Purely combinational; the decoder picks which one to use.
module id_imm_gen (
  input  logic [31:0] instr,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_u,
  output logic [31:0] imm_j
);

  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25],
                  instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31],
                  instr[19:12], instr[20],
                  instr[30:21], 1'b0};

endmodule

// File: rtl/id_ex_issue.sv
// Decode-and-issue stage: decoder, load-use hazard unit
// and the ID/EX pipeline register.
module id_ex_issue
  import my_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rf_raddr1,
  output logic [4:0]      rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output ALUControl_Enum  out_alu_ctrl,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_is_branch,
  output logic            out_is_jump,
  output logic            out_illegal
);

  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] shamt;
  logic        legal, rs1_use, rs2_use, stall;
  id_ex_t      d, q;

  assign opc   = in_instr[6:0];
  assign rd    = in_instr[11:7];
  assign f3    = in_instr[14:12];
  assign rs1   = in_instr[19:15];
  assign rs2   = in_instr[24:20];
  assign f7    = in_instr[31:25];
  assign shamt = {27'b0, rs2};

  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;

  id_imm_gen u_imm (
    .instr (in_instr),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_b (imm_b),
    .imm_u (imm_u),
    .imm_j (imm_j)
  );

  // Decode the incoming instruction into an ID/EX record.
  always_comb begin
    d          = '0;
    d.valid    = 1'b1;
    d.alu_ctrl = ALU_ADD;
    d.pc       = in_pc;
    d.rd       = rd;
    legal      = 1'b0;
    rs1_use    = 1'b0;
    rs2_use    = 1'b0;
    unique case (1'b1)
      opc == OPC_OP: begin
        rs1_use     = 1'b1;
        rs2_use     = 1'b1;
        d.op1       = rf_rdata1;
        d.op2       = rf_rdata2;
        d.reg_write = 1'b1;
        legal       = 1'b1;
        if (f3 == F3_ADD && f7 == F7_ZERO)
          d.alu_ctrl = ALU_ADD;
        else if (f3 == F3_ADD && f7 == F7_ALT)
          d.alu_ctrl = ALU_SUB;
        else if (f3 == F3_XOR)
          d.alu_ctrl = ALU_XOR;
        else if (f3 == F3_AND)
          d.alu_ctrl = ALU_AND;
        else
          legal = 1'b0;
      end
      opc == OPC_OPIMM: begin
        rs1_use     = 1'b1;
        d.op1       = rf_rdata1;
        d.op2       = imm_i;
        d.imm       = imm_i;
        d.reg_write = 1'b1;
        legal       = 1'b1;
        if (f3 == F3_ADD)
          d.alu_ctrl = ALU_ADD;
        else if (f3 == F3_XOR)
          d.alu_ctrl = ALU_XOR;
        else if (f3 == F3_AND)
          d.alu_ctrl = ALU_AND;
        else if (f3 == F3_SLL && f7 == F7_ZERO) begin
          d.alu_ctrl = ALU_SLL;
          d.op2      = shamt;
        end else if (f3 == F3_SRA && f7 == F7_ALT) begin
          d.alu_ctrl = ALU_SRA;
          d.op2      = shamt;
        end else
          legal = 1'b0;
      end
      opc == OPC_LOAD: begin
        rs1_use     = 1'b1;
        d.op1       = rf_rdata1;
        d.op2       = imm_i;
        d.imm       = imm_i;
        d.mem_read  = 1'b1;
        d.reg_write = 1'b1;
        legal       = (f3 == F3_LW);
      end
      opc == OPC_STORE: begin
        rs1_use     = 1'b1;
        rs2_use     = 1'b1;
        d.op1       = rf_rdata1;
        d.op2       = imm_s;
        d.imm       = imm_s;
        d.rs2_data  = rf_rdata2;
        d.mem_write = 1'b1;
        legal       = (f3 == F3_SW);
      end
      opc == OPC_BRANCH: begin
        rs1_use     = 1'b1;
        rs2_use     = 1'b1;
        d.op1       = rf_rdata1;
        d.op2       = rf_rdata2;
        d.imm       = imm_b;
        d.is_branch = 1'b1;
        legal       = 1'b1;
        if (f3 == F3_BNE)
          d.alu_ctrl = ALU_BNE;
        else if (f3 == F3_BLE)
          d.alu_ctrl = ALU_BLE;
        else
          legal = 1'b0;
      end
      opc == OPC_LUI: begin
        d.op2       = imm_u;
        d.imm       = imm_u;
        d.reg_write = 1'b1;
        legal       = 1'b1;
      end
      opc == OPC_AUIPC: begin
        d.op1       = in_pc;
        d.op2       = imm_u;
        d.imm       = imm_u;
        d.reg_write = 1'b1;
        legal       = 1'b1;
      end
      opc == OPC_JAL: begin
        d.op1       = in_pc;
        d.op2       = 32'd4;
        d.imm       = imm_j;
        d.is_jump   = 1'b1;
        d.reg_write = 1'b1;
        legal       = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      d          = '0;
      d.valid    = 1'b1;
      d.alu_ctrl = ALU_ADD;
      d.pc       = in_pc;
      d.illegal  = 1'b1;
    end
    if (d.rd == 5'd0)
      d.reg_write = 1'b0;
  end

  // Load-use hazard against the load held in ID/EX.
  always_comb begin
    stall = q.valid && q.mem_read && (q.rd != 5'd0) &&
            ((rs1_use && rs1 == q.rd) ||
             (rs2_use && rs2 == q.rd));
  end

  assign in_ready = !flush && !stall &&
                    (!q.valid || out_ready);

  // ID/EX register: reset > flush > load > drain/bubble.
  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (flush)
      q.valid <= 1'b0;
    else if (in_valid && in_ready)
      q <= d;
    else if (out_ready)
      q.valid <= 1'b0;
  end

  assign out_valid     = q.valid;
  assign out_alu_ctrl  = q.alu_ctrl;
  assign out_op1       = q.op1;
  assign out_op2       = q.op2;
  assign out_rs2_data  = q.rs2_data;
  assign out_imm       = q.imm;
  assign out_pc        = q.pc;
  assign out_rd        = q.rd;
  assign out_reg_write = q.reg_write;
  assign out_mem_read  = q.mem_read;
  assign out_mem_write = q.mem_write;
  assign out_is_branch = q.is_branch;
  assign out_is_jump   = q.is_jump;
  assign out_illegal   = q.illegal;

endmodule
